// File: rtl/lock_ctrl_pkg.sv
// Shared types and sizing for the lock-key query sequencer.
// Optional KEY_PARITY_CHK_EN adds an even-parity bit to the serial key load.
package lock_ctrl_pkg;

    localparam int KEY_W_DEF = 64;
    localparam int PAT_W_DEF = 41;
    localparam int CNT_W     = 7;
    localparam int SETTLE_W  = 4;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        WAIT,
        RESP
    } state_t;

endpackage

// File: rtl/lock_key_query_ctrl_key_shift_reg.sv
// Shadow key register: collects serial key bits LSB first and flags load completion.
// With KEY_PARITY_CHK_EN defined, one extra even-parity bit follows the key.
module key_shift_reg
    import lock_ctrl_pkg::*;
#(
    parameter int KEY_W = KEY_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             data_bit,
    input  logic             accept,
    input  logic             clear,
    output logic [KEY_W-1:0] key_word,
    output logic             done,
    output logic             err
);

    localparam int IDX_W = $clog2(KEY_W);
    localparam logic [CNT_W-1:0] KEY_CNT = CNT_W'(KEY_W);
`ifdef KEY_PARITY_CHK_EN
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(KEY_W);
`else
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(KEY_W - 1);
`endif

    logic [KEY_W-1:0] shadow;
    logic [CNT_W-1:0] cnt;
    logic             par_acc;

    // Shadow with the bit currently being accepted merged in, so the commit
    // edge can transfer a complete key without waiting one more cycle.
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        key_word = shadow;
        if (accept && cnt < KEY_CNT)
            key_word[cnt[IDX_W-1:0]] = data_bit;
    end

`ifdef KEY_PARITY_CHK_EN
    assign err = accept && (cnt == LAST_CNT) && (par_acc ^ data_bit);
`else
    assign err = 1'b0;
`endif
    assign done = accept && (cnt == LAST_CNT) && !err;

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow  <= '0;
            cnt     <= '0;
            par_acc <= 1'b0;
        end else if (clear || done || err) begin
            shadow  <= '0;
            cnt     <= '0;
            par_acc <= 1'b0;
        end else if (accept) begin
            shadow  <= key_word;
            cnt     <= cnt + CNT_W'(1);
            par_acc <= par_acc ^ data_bit;
        end
    end

endmodule

// File: rtl/lock_key_query_ctrl.sv
// Sequencer for a key-locked core: serial key load, then settled one-at-a-time queries.
// KEY_PARITY_CHK_EN (see key_shift_reg) enables parity-checked key loading.
module lock_key_query_ctrl
    import lock_ctrl_pkg::*;
#(
    parameter int KEY_W      = KEY_W_DEF,
    parameter int PAT_W      = PAT_W_DEF,
    parameter int SETTLE_CYC = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             key_bit_i,
    input  logic             key_bit_valid_i,
    output logic             key_bit_ready_o,
    input  logic             key_clear_i,
    output logic             key_loaded_o,
    output logic             key_err_o,
    input  logic             q_valid_i,
    output logic             q_ready_o,
    input  logic [PAT_W-1:0] q_pattern_i,
    output logic [KEY_W-1:0] core_key_o,
    output logic [PAT_W-1:0] core_pat_o,
    input  logic             core_out_i,
    output logic             r_valid_o,
    input  logic             r_ready_i,
    output logic             r_data_o,
    output logic             busy_o
);

    state_t              state;
    logic [SETTLE_W-1:0] settle_cnt;
    logic                clear_pend;
    logic                load_phase;
    logic                bit_acc;
    logic                q_acc;
    logic [KEY_W-1:0]    ks_key;
    logic                ks_done;
    logic                ks_err;

    assign load_phase      = (state == IDLE) || (state == LOAD);
    assign key_bit_ready_o = !key_loaded_o && load_phase;
    assign q_ready_o       = key_loaded_o && (state == IDLE);
    assign busy_o          = (state != IDLE);
    // A clear in the same cycle as a key bit wins and the bit is dropped.
    assign bit_acc         = key_bit_valid_i && key_bit_ready_o && !key_clear_i;
    assign q_acc           = q_valid_i && q_ready_o;

    key_shift_reg #(.KEY_W(KEY_W)) u_key_shift_reg (
        .clk      (clk),
        .rst_n    (rst_n),
        .data_bit (key_bit_i),
        .accept   (bit_acc),
        .clear    (key_clear_i && load_phase),
        .key_word (ks_key),
        .done     (ks_done),
        .err      (ks_err)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            core_key_o   <= '0;
            key_loaded_o <= 1'b0;
            key_err_o    <= 1'b0;
            core_pat_o   <= '0;
            settle_cnt   <= '0;
            clear_pend   <= 1'b0;
            r_valid_o    <= 1'b0;
            r_data_o     <= 1'b0;
        end else begin
            key_err_o <= ks_err;
            case (state)
                IDLE, LOAD: begin
                    // A clear racing an accepted query is deferred until the
                    // query completes, so it still runs with the old key.
                    if (q_acc) begin
                        core_pat_o <= q_pattern_i;
                        settle_cnt <= SETTLE_W'(SETTLE_CYC);
                        clear_pend <= key_clear_i;
                        state      <= WAIT;
                    end else if (key_clear_i) begin
                        core_key_o   <= '0;
                        key_loaded_o <= 1'b0;
                        state        <= IDLE;
                    end else if (ks_done) begin
                        core_key_o   <= ks_key;
                        key_loaded_o <= 1'b1;
                        state        <= IDLE;
                    end else if (ks_err) begin
                        state <= IDLE;
                    end else if (bit_acc) begin
                        state <= LOAD;
                    end
                end
                WAIT: begin
                    if (key_clear_i)
                        clear_pend <= 1'b1;
                    settle_cnt <= settle_cnt - SETTLE_W'(1);
                    if (settle_cnt == SETTLE_W'(1)) begin
                        r_data_o  <= core_out_i;
                        r_valid_o <= 1'b1;
                        state     <= RESP;
                    end
                end
                RESP: begin
                    if (key_clear_i)
                        clear_pend <= 1'b1;
                    if (r_ready_i) begin
                        r_valid_o <= 1'b0;
                        state     <= IDLE;
                        if (clear_pend || key_clear_i) begin
                            core_key_o   <= '0;
                            key_loaded_o <= 1'b0;
                            clear_pend   <= 1'b0;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
